// File: rtl/fp16_op_dispatch.sv
// fp16_op_dispatch: issue stage in front of the shared int/fp16 adder and
// multiplier. Requests are queued in a small circular FIFO, issued one at a
// time to both units, and the selected result is returned with its tag on a
// valid/ready response channel.
module fp16_op_dispatch #(
  parameter int WORD_LENGHT = 16,
  parameter int TAG_W       = 4,
  parameter int FIFO_DEPTH  = 2,
  parameter int ADD_LAT     = 2,
  parameter int MUL_LAT     = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [1:0]             req_op,
  input  logic                   req_mode,
  input  logic [WORD_LENGHT-1:0] req_a,
  input  logic [WORD_LENGHT-1:0] req_b,
  input  logic [TAG_W-1:0]       req_tag,
  output logic [WORD_LENGHT-1:0] unit_a,
  output logic [WORD_LENGHT-1:0] unit_b,
  output logic                   unit_mode,
  input  logic [WORD_LENGHT-1:0] add_c,
  input  logic [WORD_LENGHT-1:0] mul_c,
  input  logic                   mul_error,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WORD_LENGHT-1:0] rsp_data,
  output logic                   rsp_error,
  output logic [TAG_W-1:0]       rsp_tag
);

  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int MAX_LAT = (ADD_LAT > MUL_LAT) ? ADD_LAT : MUL_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  localparam logic [PTR_W:0]   DEPTH   = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] ADD_CNT = CNT_W'(ADD_LAT);
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT);
  localparam logic [CNT_W-1:0] LAT_ONE = CNT_W'(1);

  typedef struct packed {
    logic [1:0]             op;
    logic                   mode;
    logic [WORD_LENGHT-1:0] a;
    logic [WORD_LENGHT-1:0] b;
    logic [TAG_W-1:0]       tag;
  } req_t;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  req_t             mem [FIFO_DEPTH];
  req_t             head;
  req_t             wr_entry;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             op_mul;
  logic [TAG_W-1:0] tag_q;

  assign fifo_full  = (count == DEPTH);
  assign fifo_empty = (count == '0);
  // Ready depends only on registered occupancy; a pop on a full edge does not
  // open a slot until the following cycle.
  assign req_ready  = rst_n && !fifo_full;
  assign push       = req_valid && req_ready;
  assign head       = mem[rd_ptr];
  assign wr_entry   = '{op: req_op, mode: req_mode, a: req_a, b: req_b, tag: req_tag};

  // Issue whenever idle, or straight out of RESP on the accepting edge.
  assign pop = !fifo_empty &&
               ((state == IDLE) || ((state == RESP) && rsp_valid && rsp_ready));

  // Request storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end

  // Circular pointers (depth is a power of two, so they wrap naturally) and occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: ;
      endcase
    end
  end

  // Issue/wait/respond sequencer; operand and response registers live here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      op_mul    <= 1'b0;
      tag_q     <= '0;
      unit_a    <= '0;
      unit_b    <= '0;
      unit_mode <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_error <= 1'b0;
      rsp_tag   <= '0;
    end else begin
      case (state)
        WAIT: begin
          cnt <= cnt - LAT_ONE;
          // Final latency edge: the selected unit output is valid now.
          if (cnt == LAT_ONE) begin
            rsp_valid <= 1'b1;
            rsp_data  <= op_mul ? mul_c : add_c;
            rsp_error <= op_mul & mul_error;
            rsp_tag   <= tag_q;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      // A pop overrides the IDLE/RESP decisions above.
      if (pop) begin
        if (head.op[1]) begin
          // Illegal op never reaches the units; answer immediately.
          rsp_valid <= 1'b1;
          rsp_data  <= '0;
          rsp_error <= 1'b1;
          rsp_tag   <= head.tag;
          state     <= RESP;
        end else begin
          unit_a    <= head.a;
          unit_b    <= head.b;
          unit_mode <= head.mode;
          op_mul    <= head.op[0];
          tag_q     <= head.tag;
          cnt       <= head.op[0] ? MUL_CNT : ADD_CNT;
          state     <= WAIT;
        end
      end
    end
  end

endmodule

// File: tb/tb_fp16_op_dispatch.sv
// Bench for fp16_op_dispatch: pipelined unit stubs with the real latencies,
// directed scenarios plus a randomized stream against a queue-based model.
module tb_fp16_op_dispatch;
  localparam int W = 16, TW = 4, DEPTH = 2, ADD_LAT = 2, MUL_LAT = 3;

  logic clk = 1'b0, rst_n = 1'b0;
  logic req_valid = 1'b0, req_ready, req_mode = 1'b0;
  logic [1:0] req_op = '0;
  logic [W-1:0] req_a = '0, req_b = '0;
  logic [TW-1:0] req_tag = '0;
  logic [W-1:0] unit_a, unit_b, add_c, mul_c, rsp_data;
  logic unit_mode, mul_error, rsp_valid, rsp_ready = 1'b0, rsp_error;
  logic [TW-1:0] rsp_tag;

  int n_cmp = 0, n_bad = 0;

  typedef struct packed {logic [W-1:0] data; logic err; logic [TW-1:0] tag;} rsp_t;

  always #5 clk = ~clk;

  fp16_op_dispatch #(.WORD_LENGHT(W), .TAG_W(TW), .FIFO_DEPTH(DEPTH),
                     .ADD_LAT(ADD_LAT), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_mode(req_mode), .req_a(req_a), .req_b(req_b),
    .req_tag(req_tag), .unit_a(unit_a), .unit_b(unit_b), .unit_mode(unit_mode),
    .add_c(add_c), .mul_c(mul_c), .mul_error(mul_error), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_error(rsp_error), .rsp_tag(rsp_tag));

  // ---- arithmetic used by the unit stubs and the reference model ----
  function automatic real h2r(input logic [15:0] h);
    logic [63:0] bits;
    real r;
    if (h[14:10] == 5'd31) r = 1.0e6;
    else if (h[14:10] == 5'd0) r = real'(h[9:0]) / 16777216.0;
    else begin
      bits = {1'b0, 11'(int'(h[14:10]) + 1008), h[9:0], 42'b0};
      r = $bitstoreal(bits);
    end
    return h[15] ? -r : r;
  endfunction

  function automatic logic [15:0] r2h(input real r);
    logic [63:0] bits;
    int e;
    bits = $realtobits(r);
    e = int'(bits[62:52]) - 1008;
    if (e >= 31) return {bits[63], 5'h1f, 10'h0};
    if (e <= 0) return {bits[63], 15'h0};
    return {bits[63], e[4:0], bits[51:42]};
  endfunction

  function automatic logic [15:0] f_add(input logic [15:0] a, b, input logic m);
    return m ? r2h(h2r(a) + h2r(b)) : a + b;
  endfunction

  function automatic logic [15:0] f_mul(input logic [15:0] a, b, input logic m);
    logic [31:0] p;
    p = a * b;
    return m ? r2h(h2r(a) * h2r(b)) : p[15:0];
  endfunction

  function automatic logic f_mul_err(input logic [15:0] a, b, input logic m);
    logic [31:0] p;
    logic [15:0] h;
    p = a * b;
    h = r2h(h2r(a) * h2r(b));
    return m ? (a[14:10] == 5'd31 || b[14:10] == 5'd31 || h[14:10] == 5'd31) : (p[31:16] != 16'h0);
  endfunction

  // Expected response for one request, straight from the op rules.
  function automatic rsp_t model(input logic [1:0] op, input logic m,
                                 input logic [15:0] a, b, input logic [TW-1:0] tag);
    rsp_t r;
    r.tag = tag;
    if (op[1]) begin r.data = '0; r.err = 1'b1; end
    else if (op[0]) begin r.data = f_mul(a, b, m); r.err = f_mul_err(a, b, m); end
    else begin r.data = f_add(a, b, m); r.err = 1'b0; end
    return r;
  endfunction

  // Unit stubs: result valid exactly ADD_LAT / MUL_LAT edges after operand load.
  logic [W-1:0] add_s0, mul_s0, mul_s1;
  logic err_s0, err_s1;
  always @(posedge clk) begin
    add_s0 <= f_add(unit_a, unit_b, unit_mode);
    mul_s0 <= f_mul(unit_a, unit_b, unit_mode);
    err_s0 <= f_mul_err(unit_a, unit_b, unit_mode);
    mul_s1 <= mul_s0;
    err_s1 <= err_s0;
  end
  assign add_c = add_s0;
  assign mul_c = mul_s1;
  assign mul_error = err_s1;

  // ---- drivers ----
  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [1:0] op, input logic m, input logic [15:0] a, b,
                      input logic [TW-1:0] tag, output bit ok);
    int n = 0;
    req_valid = 1'b1; req_op = op; req_mode = m; req_a = a; req_b = b; req_tag = tag;
    while (!req_ready && n < 200) begin tick; n++; end
    ok = req_ready;
    tick;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int e);
    e = 0;
    while (!rsp_valid && e < 50) begin tick; e++; end
  endtask

  task automatic consume;
    rsp_ready = 1'b1; tick; rsp_ready = 1'b0;
  endtask

  // ---- scenarios ----
  task automatic test_reset;
    rst_n = 1'b0; tick; tick;
    n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL rst_req_ready got %b want 0", req_ready); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_rsp_valid got %b want 0", rsp_valid); end
    n_cmp++; if (rsp_data !== 16'h0) begin n_bad++; $display("FAIL rst_rsp_data got %h want 0", rsp_data); end
    n_cmp++; if (rsp_error !== 1'b0) begin n_bad++; $display("FAIL rst_rsp_error got %b want 0", rsp_error); end
    n_cmp++; if (rsp_tag !== 4'h0) begin n_bad++; $display("FAIL rst_rsp_tag got %h want 0", rsp_tag); end
    n_cmp++; if ({unit_a, unit_b, unit_mode} !== 33'h0) begin n_bad++; $display("FAIL rst_unit got %h %h %b want 0", unit_a, unit_b, unit_mode); end
    rst_n = 1'b1; tick;
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_release_ready got %b want 1", req_ready); end
  endtask

  task automatic test_add_fp;
    int e = 0;
    bit ok;
    push(2'b00, 1'b1, 16'h3C00, 16'h4000, 4'd3, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL t1_push got timeout want accept"); end
    while (!rsp_valid && e < 20) begin
      tick; e++;
      n_cmp++; if (unit_a !== 16'h3C00 || unit_b !== 16'h4000) begin n_bad++; $display("FAIL t1_unit_hold got %h %h want 3c00 4000", unit_a, unit_b); end
    end
    n_cmp++; if (e != ADD_LAT + 1) begin n_bad++; $display("FAIL t1_latency got %0d want %0d", e, ADD_LAT + 1); end
    n_cmp++; if (rsp_data !== 16'h4200) begin n_bad++; $display("FAIL t1_data got %h want 4200", rsp_data); end
    n_cmp++; if (rsp_error !== 1'b0) begin n_bad++; $display("FAIL t1_err got %b want 0", rsp_error); end
    n_cmp++; if (rsp_tag !== 4'd3) begin n_bad++; $display("FAIL t1_tag got %h want 3", rsp_tag); end
    consume;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL t1_drop got %b want 0", rsp_valid); end
  endtask

  task automatic test_mul_and_int;
    int e;
    bit ok;
    push(2'b01, 1'b1, 16'h4000, 16'h4200, 4'd5, ok);
    wait_rsp(e);
    n_cmp++; if (e != MUL_LAT + 1) begin n_bad++; $display("FAIL t2_mul_latency got %0d want %0d", e, MUL_LAT + 1); end
    n_cmp++; if ({rsp_data, rsp_error, rsp_tag} !== {16'h4600, 1'b0, 4'd5}) begin n_bad++; $display("FAIL t2_mul got %h %b %h want 4600 0 5", rsp_data, rsp_error, rsp_tag); end
    consume;
    push(2'b00, 1'b0, 16'h0005, 16'h0007, 4'd6, ok);
    wait_rsp(e);
    n_cmp++; if ({rsp_data, rsp_error, rsp_tag} !== {16'h000C, 1'b0, 4'd6}) begin n_bad++; $display("FAIL t2_int_add got %h %b %h want 000c 0 6", rsp_data, rsp_error, rsp_tag); end
    consume;
  endtask

  task automatic test_backpressure;
    rsp_t exp [3];
    rsp_t snap;
    int e, k = 0;
    bit ok0, ok1, ok2;
    exp[0] = model(2'b00, 1'b0, 16'h0001, 16'h0002, 4'd1);
    exp[1] = model(2'b01, 1'b1, 16'h3C00, 16'h4400, 4'd2);
    exp[2] = model(2'b00, 1'b0, 16'h00FF, 16'h0001, 4'd3);
    push(2'b00, 1'b0, 16'h0001, 16'h0002, 4'd1, ok0);
    push(2'b01, 1'b1, 16'h3C00, 16'h4400, 4'd2, ok1);
    push(2'b00, 1'b0, 16'h00FF, 16'h0001, 4'd3, ok2);
    n_cmp++; if (!(ok0 && ok1 && ok2)) begin n_bad++; $display("FAIL t3_push got %b%b%b want 111", ok0, ok1, ok2); end
    n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL t3_full_ready got %b want 0", req_ready); end
    wait_rsp(e);
    snap = {rsp_data, rsp_error, rsp_tag};
    n_cmp++; if (snap !== exp[0]) begin n_bad++; $display("FAIL t3_first got %h want %h", snap, exp[0]); end
    for (int c = 0; c < 10; c++) begin
      tick;
      n_cmp++; if (!rsp_valid || {rsp_data, rsp_error, rsp_tag} !== snap || req_ready !== 1'b0) begin n_bad++; $display("FAIL t3_hold got v=%b %h rdy=%b want v=1 %h rdy=0", rsp_valid, {rsp_data, rsp_error, rsp_tag}, req_ready, snap); end
    end
    rsp_ready = 1'b1;
    for (int c = 0; c < 100 && k < 3; c++) begin
      if (rsp_valid) begin
        n_cmp++; if ({rsp_data, rsp_error, rsp_tag} !== exp[k]) begin n_bad++; $display("FAIL t3_order[%0d] got %h want %h", k, {rsp_data, rsp_error, rsp_tag}, exp[k]); end
        k++;
      end
      tick;
    end
    rsp_ready = 1'b0;
    n_cmp++; if (k != 3) begin n_bad++; $display("FAIL t3_count got %0d want 3", k); end
  endtask

  task automatic test_illegal;
    logic [W-1:0] ua, ub;
    int e;
    bit ok0, ok1;
    ua = unit_a; ub = unit_b;
    push(2'b10, 1'b0, 16'h1111, 16'h2222, 4'd9, ok0);
    push(2'b01, 1'b1, 16'h4000, 16'h4000, 4'd4, ok1);
    n_cmp++; if (!(ok0 && ok1)) begin n_bad++; $display("FAIL t4_push got %b%b want 11", ok0, ok1); end
    n_cmp++; if ({rsp_valid, rsp_data, rsp_error, rsp_tag} !== {1'b1, 16'h0, 1'b1, 4'd9}) begin n_bad++; $display("FAIL t4_illegal got %b %h %b %h want 1 0000 1 9", rsp_valid, rsp_data, rsp_error, rsp_tag); end
    n_cmp++; if (unit_a !== ua || unit_b !== ub) begin n_bad++; $display("FAIL t4_unit_kept got %h %h want %h %h", unit_a, unit_b, ua, ub); end
    consume;
    n_cmp++; if (rsp_valid !== 1'b0 || unit_a !== 16'h4000) begin n_bad++; $display("FAIL t4_b2b got v=%b a=%h want v=0 a=4000", rsp_valid, unit_a); end
    wait_rsp(e);
    n_cmp++; if (e != MUL_LAT) begin n_bad++; $display("FAIL t4_b2b_latency got %0d want %0d", e, MUL_LAT); end
    n_cmp++; if ({rsp_data, rsp_error, rsp_tag} !== {16'h4400, 1'b0, 4'd4}) begin n_bad++; $display("FAIL t4_mul got %h %b %h want 4400 0 4", rsp_data, rsp_error, rsp_tag); end
    consume;
  endtask

  task automatic test_mul_error;
    logic [1:0]  op [3] = '{2'b01, 2'b01, 2'b00};
    logic        md [3] = '{1'b0, 1'b1, 1'b1};
    logic [15:0] va [3] = '{16'h0100, 16'h7800, 16'h3C00};
    logic [15:0] vd [3] = '{16'h0000, 16'h7C00, 16'h4000};
    logic        ve [3] = '{1'b1, 1'b1, 1'b0};
    int e;
    bit ok;
    for (int i = 0; i < 3; i++) begin
      push(op[i], md[i], va[i], va[i], 4'(10 + i), ok);
      wait_rsp(e);
      n_cmp++; if ({rsp_valid, rsp_data, rsp_error, rsp_tag} !== {1'b1, vd[i], ve[i], 4'(10 + i)}) begin n_bad++; $display("FAIL t5_err[%0d] got %b %h %b %h want 1 %h %b %h", i, rsp_valid, rsp_data, rsp_error, rsp_tag, vd[i], ve[i], 4'(10 + i)); end
      consume;
    end
  endtask

  task automatic test_reset_mid;
    int e;
    bit ok0, ok1, ok2, seen = 1'b0;
    push(2'b00, 1'b0, 16'h0001, 16'h0001, 4'd1, ok0);
    push(2'b01, 1'b0, 16'h0002, 16'h0003, 4'd2, ok1);
    push(2'b00, 1'b0, 16'h0004, 16'h0005, 4'd3, ok2);
    n_cmp++; if (!(ok0 && ok1 && ok2) || rsp_valid !== 1'b0) begin n_bad++; $display("FAIL t6_setup got ok=%b%b%b v=%b want 111 v=0", ok0, ok1, ok2, rsp_valid); end
    rst_n = 1'b0; #1;
    n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL t6_ready_low got %b want 0", req_ready); end
    tick;
    n_cmp++; if ({rsp_valid, rsp_data, rsp_tag, unit_a, unit_b, req_ready} !== '0) begin n_bad++; $display("FAIL t6_cleared got v=%b %h %h %h %h rdy=%b want all 0", rsp_valid, rsp_data, rsp_tag, unit_a, unit_b, req_ready); end
    tick; rst_n = 1'b1; rsp_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin tick; if (rsp_valid) seen = 1'b1; end
    rsp_ready = 1'b0;
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL t6_stale got rsp_valid seen want none"); end
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL t6_ready_after got %b want 1", req_ready); end
    push(2'b00, 1'b1, 16'h3C00, 16'h4000, 4'd3, ok0);
    wait_rsp(e);
    n_cmp++; if (e != ADD_LAT + 1) begin n_bad++; $display("FAIL t6_latency got %0d want %0d", e, ADD_LAT + 1); end
    n_cmp++; if ({rsp_data, rsp_error, rsp_tag} !== {16'h4200, 1'b0, 4'd3}) begin n_bad++; $display("FAIL t6_fresh got %h %b %h want 4200 0 3", rsp_data, rsp_error, rsp_tag); end
    consume;
  endtask

  task automatic test_random;
    localparam int N = 60;
    rsp_t q[$];
    int got = 0;
    fork
      begin
        for (int i = 0; i < N; i++) begin
          logic [1:0] op;
          logic m;
          logic [15:0] a, b;
          logic [TW-1:0] tg;
          bit ok;
          op = ($urandom_range(0, 7) == 0) ? 2'(2 + $urandom_range(0, 1)) : 2'($urandom_range(0, 1));
          m = 1'($urandom_range(0, 1));
          a = 16'($urandom); b = 16'($urandom); tg = TW'($urandom);
          repeat ($urandom_range(0, 2)) tick;
          push(op, m, a, b, tg, ok);
          n_cmp++; if (!ok) begin n_bad++; $display("FAIL rnd_push[%0d] got timeout want accept", i); end
          q.push_back(model(op, m, a, b, tg));
        end
      end
      begin
        rsp_t last, exp;
        bit hold = 1'b0;
        for (int c = 0; c < 5000 && got < N; c++) begin
          if (hold) begin
            n_cmp++; if (!rsp_valid || {rsp_data, rsp_error, rsp_tag} !== last) begin n_bad++; $display("FAIL rnd_hold got v=%b %h want v=1 %h", rsp_valid, {rsp_data, rsp_error, rsp_tag}, last); end
          end
          rsp_ready = 1'($urandom_range(0, 1));
          hold = 1'b0;
          if (rsp_valid && rsp_ready) begin
            exp = (q.size() > 0) ? q.pop_front() : '1;
            n_cmp++; if ({rsp_data, rsp_error, rsp_tag} !== exp) begin n_bad++; $display("FAIL rnd_rsp[%0d] got %h want %h", got, {rsp_data, rsp_error, rsp_tag}, exp); end
            got++;
          end else if (rsp_valid) begin
            hold = 1'b1; last = {rsp_data, rsp_error, rsp_tag};
          end
          tick;
        end
      end
    join
    rsp_ready = 1'b0;
    n_cmp++; if (got != N || q.size() != 0) begin n_bad++; $display("FAIL rnd_count got %0d left %0d want %0d left 0", got, q.size(), N); end
  endtask

  initial begin
    test_reset();
    test_add_fp();
    test_mul_and_int();
    test_backpressure();
    test_illegal();
    test_mul_error();
    test_reset_mid();
    test_random();
    repeat (3) tick;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no completion want finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fp16_op_dispatch.md
Name: fp16_op_dispatch

Overview:
- Upstream issue stage for the int/fp16 adder (int_fp_add) and multiplier (int_fp_mul).
- Accepts tagged operation requests over a valid/ready handshake and buffers them in a small FIFO.
- Drives shared operands and mode into both units, holds them stable for the unit's fixed latency, then captures the selected result (and the multiplier error flag).
- Returns the captured result with its tag over a valid/ready response channel. One operation is in flight at a time.

Parameters:
WORD_LENGHT, 16, operand/result width
TAG_W, 4, request tag width
FIFO_DEPTH, 2, request FIFO entries (power of 2, >=2)
ADD_LAT, 2, adder latency: clock edges from operand load to valid result (>=1)
MUL_LAT, 3, multiplier latency: clock edges from operand load to valid result (>=1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
req_valid  in  1  request valid
req_ready  out  1  request FIFO can accept
req_op  in  2  00 add, 01 mul, 1x illegal
req_mode  in  1  unit mode: 0 int16, 1 fp16
req_a  in  WORD_LENGHT  operand a
req_b  in  WORD_LENGHT  operand b
req_tag  in  TAG_W  request tag
unit_a  out  WORD_LENGHT  registered operand a to both units
unit_b  out  WORD_LENGHT  registered operand b to both units
unit_mode  out  1  registered mode to both units
add_c  in  WORD_LENGHT  adder result
mul_c  in  WORD_LENGHT  multiplier result
mul_error  in  1  multiplier error flag
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumer ready
rsp_data  out  WORD_LENGHT  captured result
rsp_error  out  1  mul_error for mul; 1 for illegal op; 0 for add
rsp_tag  out  TAG_W  tag of the request

Behaviour:
- Reset (rst_n low at a rising edge) clears the following; all take effect that edge:
  - FIFO empty, state IDLE, counter 0.
  - unit_a, unit_b, unit_mode = 0.
  - rsp_valid, rsp_data, rsp_error, rsp_tag = 0.
  - req_ready = 0 while rst_n is low.
- Reset mid-operation aborts the in-flight op and drops all FIFO contents. No response is produced for them.
- Request push: occurs when req_valid && req_ready at an edge.
  - req_ready = !fifo_full (registered-state based; no combinational path from rsp_ready).
  - When full, no push, even if a pop occurs the same edge.
- FIFO: circular, read/write pointers wrap modulo FIFO_DEPTH. Simultaneous push and pop when non-full and non-empty updates both pointers; count is unchanged.
- States: IDLE, WAIT, RESP.
  - IDLE, FIFO non-empty:
    - Pop the head and load unit_a/unit_b/unit_mode from it.
    - Latch op/tag internally.
    - cnt <= ADD_LAT or MUL_LAT, then go to WAIT.
    - Illegal op: do not load unit regs; go directly to RESP with rsp_data=0, rsp_error=1.
  - IDLE, FIFO empty: unit regs hold their last values.
  - WAIT: cnt decrements each edge. At the edge where cnt==1:
    - Capture add_c (rsp_error=0) or mul_c (rsp_error=mul_error) into rsp_data.
    - Load rsp_tag, set rsp_valid=1, go to RESP.
    - Result is sampled exactly LAT edges after the operand load edge.
  - RESP: rsp_valid, rsp_data, rsp_error, rsp_tag are held stable until rsp_valid && rsp_ready at an edge. On that edge:
    - FIFO non-empty: pop and load the next op in the same edge (back-to-back; rsp_valid deasserts for at least LAT cycles).
    - Otherwise go to IDLE.
- Latency: push at edge N into an empty FIFO while IDLE gives pop/load at N+1, capture at N+1+LAT, and rsp_valid high from then on (fp16 mul with MUL_LAT=3 gives rsp_valid in the cycle after edge N+4).
- unit_a, unit_b, unit_mode never change during WAIT.
- Responses are returned in request order; tags are passed through and not interpreted.

Test Plan:
1. Reset, then one fp16 add: a=0x3C00 (1.0), b=0x4000 (2.0), tag=3 -> rsp_data=0x4200, rsp_error=0, rsp_tag=3, rsp_valid rises exactly ADD_LAT+1 edges after the push edge.
2. fp16 mul: a=0x4000, b=0x4200, tag=5 -> rsp_data=0x4600 (6.0), rsp_error=0. Then int16 add: a=0x0005, b=0x0007, mode=0 -> rsp_data=0x000C.
3. Backpressure: rsp_ready=0 for 10 cycles, push three requests with FIFO_DEPTH=2 -> req_ready drops after two buffered entries. rsp outputs remain stable. Releasing rsp_ready returns all three in order with correct tags.
4. Illegal op req_op=2'b10, tag=9, followed by a valid mul -> first response rsp_data=0, rsp_error=1, tag=9, arriving one edge after pop. unit_a/unit_b stay unchanged. The mul completes normally afterwards.
5. Mul error: multiplier model asserts mul_error for the operands used -> rsp_error=1, tag preserved. A following add returns rsp_error=0.
6. Reset asserted during WAIT with two entries queued -> next edge: rsp_valid=0, req_ready=0 while low, FIFO empty. After release, no stale responses appear; a fresh add behaves as in scenario 1.
